// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the two-master bus arbiter.
// The optional round-robin mode is selected with BUS_ARB_FAIR_EN in bus_arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } bus_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  localparam int DEF_WAIT_STATES = 2;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DATA_W      = 8;
  // Wait states range 0..15, so four counter bits are enough.
  localparam int WAIT_W          = 4;

endpackage

// File: rtl/bus_wait_counter.sv
// Wait-state down-counter: loads the wait-state count at the start of a bus
// cycle, counts down once per ACCESS cycle and flags when it reaches zero.
module bus_wait_counter
  import bus_arb_pkg::*;
#(
  parameter int W = WAIT_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master (CPU/DMA) single-slave bus arbiter with programmable wait states.
// Define BUS_ARB_FAIR_EN for round-robin on simultaneous requests; otherwise CPU wins.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int WAIT_STATES = DEF_WAIT_STATES,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_we,
  output logic              cpu_gnt,
  output logic              dma_gnt,
  output logic              cpu_ack,
  output logic              dma_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] addressBus,
  output logic [DATA_W-1:0] dataOutBus,
  output logic              writeEnBus,
  input  logic [DATA_W-1:0] dataInBus
);

  bus_state_t        state_q, state_d;
  owner_t            owner_q, winner;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [DATA_W-1:0] rdata_q;
  logic              load, dec, capture, wait_zero;

  bus_wait_counter #(
    .W(WAIT_W)
  ) u_wait_counter (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .load_value(WAIT_W'(WAIT_STATES)),
    .dec       (dec),
    .zero      (wait_zero)
  );

`ifdef BUS_ARB_FAIR_EN
  owner_t last_owner_q;

  always_comb begin
    winner = OWN_CPU;
    if (cpu_req && dma_req) begin
      winner = (last_owner_q == OWN_CPU) ? OWN_DMA : OWN_CPU;
    end else if (dma_req) begin
      winner = OWN_DMA;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_owner_q <= OWN_CPU;
    end else if (load) begin
      last_owner_q <= winner;
    end
  end
`else
  // Fixed priority: DMA only gets the bus when the CPU is not asking.
  always_comb begin
    winner = OWN_CPU;
    if (!cpu_req && dma_req) begin
      winner = OWN_DMA;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Requests are only looked at in IDLE, so anything the masters do
  // during ACCESS or DONE has no effect on the running cycle.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    dec     = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          state_d = ACCESS;
          load    = 1'b1;
        end
      end
      ACCESS: begin
        if (wait_zero) begin
          state_d = DONE;
          capture = !we_q;
        end else begin
          dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q <= OWN_CPU;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (load) begin
        owner_q <= winner;
        addr_q  <= (winner == OWN_DMA) ? dma_addr  : cpu_addr;
        wdata_q <= (winner == OWN_DMA) ? dma_wdata : cpu_wdata;
        we_q    <= (winner == OWN_DMA) ? dma_we    : cpu_we;
      end
      if (capture) begin
        rdata_q <= dataInBus;
      end
    end
  end

  // The latched address and write data double as the held bus values outside ACCESS.
  always_comb begin
    cpu_gnt    = (state_q != IDLE) && (owner_q == OWN_CPU);
    dma_gnt    = (state_q != IDLE) && (owner_q == OWN_DMA);
    cpu_ack    = (state_q == DONE) && (owner_q == OWN_CPU);
    dma_ack    = (state_q == DONE) && (owner_q == OWN_DMA);
    writeEnBus = (state_q == ACCESS) && we_q;
    addressBus = addr_q;
    dataOutBus = wdata_q;
    rdata      = rdata_q;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter: a WAIT_STATES=2 instance for most scenarios
// and a WAIT_STATES=0 instance for the zero-wait DMA write.
module tb_bus_arbiter;

  logic        clock;
  logic        reset;
  logic        cpu_req, dma_req, cpu_we, dma_we;
  logic [15:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata, data_in;
  logic        cpu_gnt, dma_gnt, cpu_ack, dma_ack, writeEnBus;
  logic [7:0]  rdata, dataOutBus;
  logic [15:0] addressBus;

  logic        z_cpu_req, z_dma_req, z_dma_we;
  logic [15:0] z_dma_addr;
  logic [7:0]  z_dma_wdata, z_data_in;
  logic        z_cpu_gnt, z_dma_gnt, z_cpu_ack, z_dma_ack, z_writeEnBus;
  logic [7:0]  z_rdata, z_dataOutBus;
  logic [15:0] z_addressBus;

  int checks = 0;
  int passes = 0;

  bus_arbiter #(.WAIT_STATES(2), .ADDR_W(16), .DATA_W(8)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we),
    .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt), .cpu_ack(cpu_ack), .dma_ack(dma_ack),
    .rdata(rdata), .addressBus(addressBus), .dataOutBus(dataOutBus),
    .writeEnBus(writeEnBus), .dataInBus(data_in)
  );

  bus_arbiter #(.WAIT_STATES(0), .ADDR_W(16), .DATA_W(8)) dut_ws0 (
    .clock(clock), .reset(reset),
    .cpu_req(z_cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .dma_req(z_dma_req), .dma_addr(z_dma_addr), .dma_wdata(z_dma_wdata), .dma_we(z_dma_we),
    .cpu_gnt(z_cpu_gnt), .dma_gnt(z_dma_gnt), .cpu_ack(z_cpu_ack), .dma_ack(z_dma_ack),
    .rdata(z_rdata), .addressBus(z_addressBus), .dataOutBus(z_dataOutBus),
    .writeEnBus(z_writeEnBus), .dataInBus(z_data_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance past the next rising edge so outputs are sampled and inputs driven mid-cycle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({cpu_gnt, dma_gnt, cpu_ack, dma_ack, writeEnBus} !== 5'b0)
      $display("[TB] FAIL reset_ctrl: got %b expected %b", {cpu_gnt, dma_gnt, cpu_ack, dma_ack, writeEnBus}, 5'b0);
    else passes++;
    checks++;
    if (addressBus !== 16'h0000) $display("[TB] FAIL reset_addr: got %h expected %h", addressBus, 16'h0000);
    else passes++;
    checks++;
    if (dataOutBus !== 8'h00) $display("[TB] FAIL reset_dout: got %h expected %h", dataOutBus, 8'h00);
    else passes++;
    checks++;
    if (rdata !== 8'h00) $display("[TB] FAIL reset_rdata: got %h expected %h", rdata, 8'h00);
    else passes++;
    checks++;
    if ({z_rdata, z_addressBus, z_dma_gnt, z_writeEnBus} !== 26'b0)
      $display("[TB] FAIL reset_ws0: got %h expected %h", {z_rdata, z_addressBus, z_dma_gnt, z_writeEnBus}, 26'b0);
    else passes++;
    reset = 1'b0;
    tick();
    checks++;
    if ({cpu_gnt, dma_gnt, cpu_ack, dma_ack} !== 4'b0)
      $display("[TB] FAIL idle_after_reset: got %b expected %b", {cpu_gnt, dma_gnt, cpu_ack, dma_ack}, 4'b0);
    else passes++;
  endtask

  task automatic test_cpu_read();
    cpu_req  = 1'b1;
    cpu_addr = 16'h0100;
    cpu_we   = 1'b0;
    data_in  = 8'h5A;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (addressBus !== 16'h0100) $display("[TB] FAIL read_addr_c%0d: got %h expected %h", c, addressBus, 16'h0100);
      else passes++;
      checks++;
      if ({cpu_gnt, cpu_ack, writeEnBus} !== 3'b100)
        $display("[TB] FAIL read_access_c%0d: got %b expected %b", c, {cpu_gnt, cpu_ack, writeEnBus}, 3'b100);
      else passes++;
    end
    tick();
    checks++;
    if ({cpu_gnt, cpu_ack, writeEnBus} !== 3'b110)
      $display("[TB] FAIL read_done: got %b expected %b", {cpu_gnt, cpu_ack, writeEnBus}, 3'b110);
    else passes++;
    checks++;
    if (rdata !== 8'h5A) $display("[TB] FAIL read_rdata: got %h expected %h", rdata, 8'h5A);
    else passes++;
    cpu_req = 1'b0;
    data_in = 8'h00;
    tick();
    checks++;
    if ({cpu_gnt, cpu_ack} !== 2'b00) $display("[TB] FAIL read_release: got %b expected %b", {cpu_gnt, cpu_ack}, 2'b00);
    else passes++;
    checks++;
    if (rdata !== 8'h5A) $display("[TB] FAIL read_rdata_hold: got %h expected %h", rdata, 8'h5A);
    else passes++;
  endtask

  task automatic test_dma_write_ws0();
    z_dma_req   = 1'b1;
    z_dma_addr  = 16'hF000;
    z_dma_wdata = 8'hC3;
    z_dma_we    = 1'b1;
    z_data_in   = 8'h77;
    tick();
    checks++;
    if ({z_dma_gnt, z_writeEnBus, z_dma_ack} !== 3'b110)
      $display("[TB] FAIL ws0_access: got %b expected %b", {z_dma_gnt, z_writeEnBus, z_dma_ack}, 3'b110);
    else passes++;
    checks++;
    if ({z_addressBus, z_dataOutBus} !== {16'hF000, 8'hC3})
      $display("[TB] FAIL ws0_bus: got %h expected %h", {z_addressBus, z_dataOutBus}, {16'hF000, 8'hC3});
    else passes++;
    tick();
    checks++;
    if ({z_dma_gnt, z_writeEnBus, z_dma_ack} !== 3'b101)
      $display("[TB] FAIL ws0_done: got %b expected %b", {z_dma_gnt, z_writeEnBus, z_dma_ack}, 3'b101);
    else passes++;
    checks++;
    if (z_rdata !== 8'h00) $display("[TB] FAIL ws0_rdata: got %h expected %h", z_rdata, 8'h00);
    else passes++;
    z_dma_req = 1'b0;
    tick();
    checks++;
    if ({z_dma_gnt, z_dma_ack, z_writeEnBus} !== 3'b000)
      $display("[TB] FAIL ws0_idle: got %b expected %b", {z_dma_gnt, z_dma_ack, z_writeEnBus}, 3'b000);
    else passes++;
    checks++;
    if (z_dataOutBus !== 8'hC3) $display("[TB] FAIL ws0_dout_hold: got %h expected %h", z_dataOutBus, 8'hC3);
    else passes++;
  endtask

  task automatic test_reset_abort();
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 16'h2222;
    cpu_wdata = 8'h99;
    data_in   = 8'hEE;
    tick();
    tick();
    checks++;
    if ({cpu_gnt, writeEnBus, cpu_ack} !== 3'b110)
      $display("[TB] FAIL abort_second_access: got %b expected %b", {cpu_gnt, writeEnBus, cpu_ack}, 3'b110);
    else passes++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({cpu_gnt, cpu_ack, writeEnBus} !== 3'b000)
      $display("[TB] FAIL abort_ctrl: got %b expected %b", {cpu_gnt, cpu_ack, writeEnBus}, 3'b000);
    else passes++;
    checks++;
    if ({addressBus, dataOutBus, rdata} !== 32'h0)
      $display("[TB] FAIL abort_regs: got %h expected %h", {addressBus, dataOutBus, rdata}, 32'h0);
    else passes++;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if ({cpu_gnt, cpu_ack, writeEnBus} !== 3'b101)
        $display("[TB] FAIL reissue_access_c%0d: got %b expected %b", c, {cpu_gnt, cpu_ack, writeEnBus}, 3'b101);
      else passes++;
    end
    tick();
    checks++;
    if ({cpu_gnt, cpu_ack, writeEnBus} !== 3'b110)
      $display("[TB] FAIL reissue_done: got %b expected %b", {cpu_gnt, cpu_ack, writeEnBus}, 3'b110);
    else passes++;
    checks++;
    if (rdata !== 8'h00) $display("[TB] FAIL reissue_rdata: got %h expected %h", rdata, 8'h00);
    else passes++;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    tick();
  endtask

  task automatic test_stale_req();
    logic [10:1] exp_gnt = 10'b0111101111;
    logic [10:1] exp_ack = 10'b0100001000;
    logic [10:1] exp_we  = 10'b0011100000;
    logic [15:0] exp_addr;
    cpu_req  = 1'b1;
    cpu_addr = 16'h0ABC;
    cpu_we   = 1'b0;
    data_in  = 8'h3C;
    for (int c = 1; c <= 10; c++) begin
      tick();
      exp_addr = (c <= 5) ? 16'h0ABC : 16'hFFFF;
      checks++;
      if ({cpu_gnt, cpu_ack, writeEnBus} !== {exp_gnt[c], exp_ack[c], exp_we[c]})
        $display("[TB] FAIL stale_ctrl_c%0d: got %b expected %b", c, {cpu_gnt, cpu_ack, writeEnBus},
                 {exp_gnt[c], exp_ack[c], exp_we[c]});
      else passes++;
      checks++;
      if (addressBus !== exp_addr) $display("[TB] FAIL stale_addr_c%0d: got %h expected %h", c, addressBus, exp_addr);
      else passes++;
      checks++;
      if ({dma_gnt, dma_ack} !== 2'b00) $display("[TB] FAIL stale_onehot_c%0d: got %b expected %b", c, {dma_gnt, dma_ack}, 2'b00);
      else passes++;
      if (c == 4 || c == 9) begin
        checks++;
        if (rdata !== 8'h3C) $display("[TB] FAIL stale_rdata_c%0d: got %h expected %h", c, rdata, 8'h3C);
        else passes++;
      end
      if (c == 1) begin
        cpu_addr = 16'hFFFF;
        cpu_we   = 1'b1;
      end
      if (c == 5) data_in = 8'h11;
      if (c == 6) begin
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_dma;
    dma_req  = 1'b1;
    dma_addr = 16'h4000;
    dma_we   = 1'b0;
    data_in  = 8'h66;
    for (int c = 1; c <= 4; c++) tick();
    checks++;
    if ({cpu_ack, dma_ack, dma_gnt} !== 3'b011)
      $display("[TB] FAIL dma_alone_done: got %b expected %b", {cpu_ack, dma_ack, dma_gnt}, 3'b011);
    else passes++;
    checks++;
    if (rdata !== 8'h66) $display("[TB] FAIL dma_alone_rdata: got %h expected %h", rdata, 8'h66);
    else passes++;
    dma_req = 1'b0;
    tick();
    cpu_req  = 1'b1;
    dma_req  = 1'b1;
    cpu_addr = 16'h1000;
    dma_addr = 16'h2000;
    cpu_we   = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      checks++;
      if ({cpu_gnt, dma_gnt} === 2'b11 || {cpu_ack, dma_ack} === 2'b11)
        $display("[TB] FAIL b2b_onehot_t%0d: got %b expected at most one gnt and one ack", t, {cpu_gnt, dma_gnt, cpu_ack, dma_ack});
      else passes++;
`ifndef BUS_ARB_FAIR_EN
      checks++;
      if (dma_gnt !== 1'b0) $display("[TB] FAIL b2b_dma_starved_t%0d: got %b expected %b", t, dma_gnt, 1'b0);
      else passes++;
`endif
      if (t % 5 == 4) begin
`ifdef BUS_ARB_FAIR_EN
        exp_dma = ((t / 5) % 2 == 1);
`else
        exp_dma = 1'b0;
`endif
        checks++;
        if ({cpu_ack, dma_ack} !== {!exp_dma, exp_dma})
          $display("[TB] FAIL b2b_owner_t%0d: got %b expected %b", t, {cpu_ack, dma_ack}, {!exp_dma, exp_dma});
        else passes++;
        checks++;
        if (addressBus !== (exp_dma ? 16'h2000 : 16'h1000))
          $display("[TB] FAIL b2b_addr_t%0d: got %h expected %h", t, addressBus, exp_dma ? 16'h2000 : 16'h1000);
        else passes++;
      end
      if (t == 19) begin
        cpu_req = 1'b0;
        dma_req = 1'b0;
      end
    end
    checks++;
    if ({cpu_gnt, dma_gnt} !== 2'b00) $display("[TB] FAIL b2b_final_idle: got %b expected %b", {cpu_gnt, dma_gnt}, 2'b00);
    else passes++;
  endtask

  initial begin
    reset     = 1'b1;
    cpu_req   = 1'b0; dma_req   = 1'b0;
    cpu_we    = 1'b0; dma_we    = 1'b0;
    cpu_addr  = '0;   dma_addr  = '0;
    cpu_wdata = '0;   dma_wdata = '0;
    data_in   = '0;
    z_cpu_req = 1'b0; z_dma_req = 1'b0; z_dma_we = 1'b0;
    z_dma_addr = '0;  z_dma_wdata = '0; z_data_in = '0;
    test_reset();
    test_cpu_read();
    test_dma_write_ws0();
    test_reset_abort();
    test_stale_req();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 2, the number of extra ACCESS cycles per bus cycle (legal 0..15).
REQ-002 SHALL have parameter ADDR_W, default 16, the memory address width.
REQ-003 SHALL have parameter DATA_W, default 8, the memory data width.
REQ-004 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-006 SHALL have ports cpu_req / dma_req, input, 1 each, meaning bus cycle requested.
REQ-007 SHALL have ports cpu_addr / dma_addr, input, ADDR_W each, meaning request address.
REQ-008 SHALL have ports cpu_wdata / dma_wdata, input, DATA_W each, meaning write data.
REQ-009 SHALL have ports cpu_we / dma_we, input, 1 each, meaning 1 = write and 0 = read.
REQ-010 SHALL have ports cpu_gnt / dma_gnt, output, 1 each, meaning the bus is owned by that requester.
REQ-011 SHALL have ports cpu_ack / dma_ack, output, 1 each, a one-cycle completion pulse.
REQ-012 SHALL have port rdata, output, DATA_W, read data, valid while any ack is high.
REQ-013 SHALL have port addressBus, output, ADDR_W; port dataOutBus, output, DATA_W; port writeEnBus, output, 1; and port dataInBus, input, DATA_W, together forming the memory side.

Function
REQ-014 SHALL implement the FSM states IDLE, ACCESS and DONE.
REQ-015 IDLE with any req high SHALL, at the next edge, latch the winner's addr, wdata and we, raise that winner's gnt, load wait_cnt=WAIT_STATES, and go to ACCESS.
REQ-016 In ACCESS, addressBus and dataOutBus SHALL come from the latched registers, and writeEnBus SHALL equal the latched we.
REQ-017 ACCESS SHALL last exactly WAIT_STATES+1 cycles: wait_cnt decrements each cycle and the FSM moves to DONE on the edge where wait_cnt==0.
REQ-018 At ACCESS exit on a read, dataInBus SHALL be captured into rdata; on a write, rdata SHALL hold its previous value.
REQ-019 DONE SHALL last one cycle, with the owner's ack=1, writeEnBus=0 and gnt still high, then go to IDLE with gnt=0.
REQ-020 Latency SHALL be WAIT_STATES+2 edges from the edge that samples req to ack high; minimum bus-cycle spacing is WAIT_STATES+3 cycles.
REQ-021 A requester SHALL drop req on the edge where it samples ack=1; the arbiter samples req only in IDLE, so a stale req there starts a new cycle.
REQ-022 Changes to req, addr, wdata or we during ACCESS or DONE SHALL be ignored.
REQ-023 On simultaneous requests in IDLE, the arbitration rule SHALL be set by REQ-028 and REQ-029.
REQ-024 Outside ACCESS, addressBus SHALL hold its last driven value and dataOutBus SHALL hold the latched wdata.
REQ-025 At most one gnt and at most one ack SHALL be high in any cycle.

Reset
REQ-026 reset=1 at an edge SHALL force, from any state including mid-ACCESS: IDLE; all gnt=0; all ack=0; writeEnBus=0; addressBus=0; dataOutBus=0; rdata=0; wait_cnt=0; last_owner=CPU.
REQ-027 An aborted bus cycle SHALL NOT produce an ack; the requester reissues it after reset.

Configuration
REQ-028 With BUS_ARB_FAIR_EN defined, simultaneous requests SHALL be granted round-robin: the requester not equal to last_owner wins, and last_owner updates on each grant.
REQ-029 Without BUS_ARB_FAIR_EN, the CPU SHALL always win simultaneous requests, no last_owner register SHALL exist, and DMA may starve; this is accepted.

Structure
REQ-030 Package bus_arb_pkg SHALL hold the state enum (IDLE, ACCESS, DONE), the owner constants OWN_CPU=0 and OWN_DMA=1, and the default WAIT_STATES.
REQ-031 The wait-state down-counter (load, decrement, zero flag) SHALL be a sub-module named bus_wait_counter; all other logic stays flat in bus_arbiter.

Verification
REQ-032 CPU read, WAIT_STATES=2, cpu_addr=16'h0100, dataInBus=8'h5A -> cpu_gnt at edge 1, addressBus=16'h0100 for 3 cycles, cpu_ack and rdata=8'h5A at edge 4.
REQ-033 DMA write, addr=16'hF000, wdata=8'hC3, WAIT_STATES=0 -> writeEnBus high exactly 1 cycle with dataOutBus=8'hC3, dma_ack at edge 2, rdata unchanged.
REQ-034 Both req high continuously for 4 bus cycles -> with BUS_ARB_FAIR_EN grants go CPU, DMA, CPU, DMA; without it, CPU x4 and dma_gnt never high.
REQ-035 reset asserted during the second ACCESS cycle of a CPU write -> next cycle: IDLE, writeEnBus=0, no cpu_ack ever issued, then reissued req completes normally.
REQ-036 cpu_addr changed mid-ACCESS, and req held one cycle after ack -> addressBus unchanged; a second bus cycle starts from IDLE (stale-req rule); gnt/ack one-hot checked every cycle.
